// File: rtl/dino_game_pkg.sv
// Shared dino-game definitions: obstacle type codes, position width helper,
// default spawn/gap constants and the divider-free type reduction.
package dino_game_pkg;

  typedef enum logic [2:0] {
    OBS_CACTUS_SMALL = 3'd0,
    OBS_CACTUS_LARGE = 3'd1,
    OBS_CACTUS_GROUP = 3'd2,
    OBS_BIRD_LOW     = 3'd3,
    OBS_BIRD_MID     = 3'd4,
    OBS_BIRD_HIGH    = 3'd5
  } obs_type_e;

  localparam int DEF_CONV     = 2;
  localparam int DEF_SPAWN_X  = 160;
  localparam int DEF_MIN_GAP  = 24;
  localparam int DEF_GAP_MASK = 31;

  function automatic int posWidth(input int conv);
    return 10 - conv;
  endfunction

  // A 3-bit raw value is below 2*numTypes for any numTypes >= 4, so one
  // conditional subtract is enough; numTypes == 8 passes raw through.
  function automatic logic [2:0] reduceType(input logic [2:0] raw, input int numTypes);
    logic [2:0] n;
    n = 3'(numTypes);
    if (numTypes < 8 && raw >= n) return raw - n;
    return raw;
  endfunction

endpackage

// File: rtl/obstacle_manager_n_slot.sv
// One obstacle slot: position/type/valid registers with scroll, despawn
// (clamped at zero, never wrapping) and a load port used for spawning.
module obstacle_slot
  import dino_game_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_scroll,
  input  logic [2:0]    i_speed,
  input  logic          i_load,
  input  logic [PW-1:0] i_loadPos,
  input  logic [2:0]    i_loadType,
  output logic [PW-1:0] o_pos,
  output logic [2:0]    o_type,
  output logic          o_valid
);

  logic [PW-1:0] r_pos;
  logic [2:0]    r_type;
  logic          r_valid;
  logic [PW-1:0] w_step;

  assign w_step = PW'(i_speed);

  // Load takes priority over scroll so a spawn is never moved on its own tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos   <= '0;
      r_type  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_pos   <= '0;
      r_type  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pos   <= i_loadPos;
      r_type  <= i_loadType;
      r_valid <= 1'b1;
    end else if (i_scroll && r_valid) begin
      if (r_pos < w_step) begin
        r_pos   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_pos <= r_pos - w_step;
      end
    end
  end

  assign o_pos   = r_pos;
  assign o_type  = r_type;
  assign o_valid = r_valid;

endmodule

// File: rtl/obstacle_manager_n.sv
// NUM_OBS-slot obstacle engine: RNG-driven spawn gap timer, lowest-free-slot
// spawning, per-tick scrolling and a saturating speed ramp.
module obstacle_manager_n
  import dino_game_pkg::*;
#(
  parameter int CONV        = DEF_CONV,
  parameter int NUM_OBS     = 3,
  parameter int NUM_TYPES   = 6,
  parameter int SPAWN_X     = DEF_SPAWN_X,
  parameter int MIN_GAP     = DEF_MIN_GAP,
  parameter int GAP_MASK    = DEF_GAP_MASK,
  parameter int START_DELAY = 40,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 4,
  parameter int RAMP_TICKS  = 600
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          game_tick,
  input  logic                          game_start,
  input  logic                          game_frozen,
  input  logic [7:0]                    rng,
  output logic [NUM_OBS*(10-CONV)-1:0]  obstacle_pos,
  output logic [NUM_OBS*3-1:0]          obstacle_type,
  output logic [NUM_OBS-1:0]            obstacle_valid,
  output logic [2:0]                    speed,
  output logic                          spawn_pulse
);

  localparam int PW = posWidth(CONV);
  localparam int RW = $clog2(RAMP_TICKS);

  logic [7:0]         r_gap;
  logic [RW-1:0]      r_ramp;
  logic [2:0]         r_speed;
  logic               r_spawnPulse;

  logic               w_advance;
  logic               w_spawnNow;
  logic               w_anyFree;
  logic [NUM_OBS-1:0] w_loadOH;
  logic [NUM_OBS-1:0] w_valid;
  logic [2:0]         w_spawnType;
  logic [7:0]         w_nextGap;

  assign w_advance   = game_tick && !game_frozen && !game_start;
  assign w_spawnNow  = w_advance && (r_gap == 8'd0);
  assign w_spawnType = reduceType(rng[2:0], NUM_TYPES);
  assign w_nextGap   = 8'(MIN_GAP) + ({3'b000, rng[7:3]} & 8'(GAP_MASK));

  // Lowest-index free slot, judged on the valid bits before this tick's scroll.
  always_comb begin
    w_loadOH  = '0;
    w_anyFree = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (!w_valid[i] && !w_anyFree) begin
        w_loadOH[i] = w_spawnNow;
        w_anyFree   = 1'b1;
      end
    end
  end

  // Gap timer holds at zero while every slot is busy, retrying each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap        <= 8'(START_DELAY);
      r_ramp       <= '0;
      r_speed      <= 3'(SPEED_INIT);
      r_spawnPulse <= 1'b0;
    end else begin
      r_spawnPulse <= 1'b0;
      if (game_start) begin
        r_gap   <= 8'(START_DELAY);
        r_ramp  <= '0;
        r_speed <= 3'(SPEED_INIT);
      end else if (w_advance) begin
        if (r_gap != 8'd0) begin
          r_gap <= r_gap - 8'd1;
        end else if (w_anyFree) begin
          r_gap        <= w_nextGap;
          r_spawnPulse <= 1'b1;
        end
        if (r_ramp == RW'(RAMP_TICKS - 1)) begin
          r_ramp <= '0;
          if (r_speed < 3'(SPEED_MAX)) r_speed <= r_speed + 3'd1;
        end else begin
          r_ramp <= r_ramp + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
    obstacle_slot #(.PW(PW)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (game_start),
      .i_scroll   (w_advance),
      .i_speed    (r_speed),
      .i_load     (w_loadOH[g]),
      .i_loadPos  (PW'(SPAWN_X)),
      .i_loadType (w_spawnType),
      .o_pos      (obstacle_pos[g*PW +: PW]),
      .o_type     (obstacle_type[g*3 +: 3]),
      .o_valid    (w_valid[g])
    );
  end

  assign obstacle_valid = w_valid;
  assign speed          = r_speed;
  assign spawn_pulse    = r_spawnPulse;

endmodule

// File: tb/tb_obstacle_manager_n.sv
// Randomized bench for obstacle_manager_n: a slot-array model of the game
// rules is checked every cycle, plus literal checkpoints that pin the model.
module tb_obstacle_manager_n;

  localparam int NUM_OBS    = 3;
  localparam int PW         = 8;
  localparam int NUM_TYPES  = 6;
  localparam int SPAWN_X    = 160;
  localparam int MIN_GAP    = 24;
  localparam int GAP_MASK   = 31;
  localparam int START_DLY  = 40;
  localparam int SPEED_INIT = 1;
  localparam int SPEED_MAX  = 4;
  localparam int RAMP_TICKS = 600;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  gameTick;
  logic                  gameStart;
  logic                  gameFrozen;
  logic [7:0]            rng;
  logic [NUM_OBS*PW-1:0] obstaclePos;
  logic [NUM_OBS*3-1:0]  obstacleType;
  logic [NUM_OBS-1:0]    obstacleValid;
  logic [2:0]            speedOut;
  logic                  spawnPulse;

  int assertCount = 0;
  int failCount   = 0;

  int mPos   [NUM_OBS];
  int mType  [NUM_OBS];
  bit mValid [NUM_OBS];
  int mSpeed, mGap, mRamp;
  bit mPulse;

  obstacle_manager_n dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .game_tick      (gameTick),
    .game_start     (gameStart),
    .game_frozen    (gameFrozen),
    .rng            (rng),
    .obstacle_pos   (obstaclePos),
    .obstacle_type  (obstacleType),
    .obstacle_valid (obstacleValid),
    .speed          (speedOut),
    .spawn_pulse    (spawnPulse)
  );

  always #5 clk = ~clk;

  // Behavioural model of the game rules, stepped on each active edge.
  always @(posedge clk or negedge rst_n) begin
    int freeIdx;
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        mPos[i] = 0; mType[i] = 0; mValid[i] = 0;
      end
      mSpeed = SPEED_INIT; mGap = START_DLY; mRamp = 0; mPulse = 0;
    end else begin
      mPulse = 0;
      if (gameStart) begin
        for (int i = 0; i < NUM_OBS; i++) begin
          mPos[i] = 0; mType[i] = 0; mValid[i] = 0;
        end
        mSpeed = SPEED_INIT; mGap = START_DLY; mRamp = 0;
      end else if (!gameFrozen && gameTick) begin
        freeIdx = -1;
        for (int i = NUM_OBS - 1; i >= 0; i--)
          if (!mValid[i]) freeIdx = i;
        for (int i = 0; i < NUM_OBS; i++) begin
          if (mValid[i]) begin
            if (mPos[i] < mSpeed) begin
              mValid[i] = 0; mPos[i] = 0;
            end else begin
              mPos[i] = mPos[i] - mSpeed;
            end
          end
        end
        if (mGap != 0) begin
          mGap = mGap - 1;
        end else if (freeIdx >= 0) begin
          mValid[freeIdx] = 1;
          mPos[freeIdx]   = SPAWN_X;
          mType[freeIdx]  = int'(rng[2:0]) % NUM_TYPES;
          mGap            = MIN_GAP + (int'(rng[7:3]) & GAP_MASK);
          mPulse          = 1;
        end
        mRamp = mRamp + 1;
        if (mRamp == RAMP_TICKS) begin
          mRamp = 0;
          if (mSpeed < SPEED_MAX) mSpeed = mSpeed + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle out of reset the DUT must match the model exactly.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        checkOutput($sformatf("slot%0d valid", i), int'(obstacleValid[i]), int'(mValid[i]));
        checkOutput($sformatf("slot%0d pos", i), int'(obstaclePos[i*PW +: PW]), mPos[i]);
        checkOutput($sformatf("slot%0d type", i), int'(obstacleType[i*3 +: 3]), mType[i]);
      end
      checkOutput("speed", int'(speedOut), mSpeed);
      checkOutput("spawn_pulse", int'(spawnPulse), int'(mPulse));
    end
  end

  task automatic applyStimulus(input bit tick, input bit start, input bit frozen,
                               input logic [7:0] r);
    gameTick   = tick;
    gameStart  = start;
    gameFrozen = frozen;
    rng        = r;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; gameTick = 0; gameStart = 0; gameFrozen = 0; rng = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset speed", int'(speedOut), 1);
    checkOutput("reset valid", int'(obstacleValid), 0);
    checkOutput("reset pulse", int'(spawnPulse), 0);

    // First spawn: gap counts 40 down to 0, the following tick spawns.
    applyStimulus(0, 1, 0, 8'hF7);
    repeat (40) applyStimulus(1, 0, 0, 8'hF7);
    checkOutput("no spawn before gap expires", int'(obstacleValid), 0);
    applyStimulus(1, 0, 0, 8'hF7);
    checkOutput("first spawn valid", int'(obstacleValid), 1);
    checkOutput("first spawn pos", int'(obstaclePos[0 +: PW]), 160);
    checkOutput("first spawn type", int'(obstacleType[0 +: 3]), 1);
    checkOutput("first spawn pulse", int'(spawnPulse), 1);
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("pulse one cycle", int'(spawnPulse), 0);
    applyStimulus(1, 0, 0, 8'h00);
    checkOutput("first move pos", int'(obstaclePos[0 +: PW]), 159);

    // Frozen ticks are dropped; then a start lands even while frozen.
    for (int i = 0; i < 100; i++) applyStimulus(1, 0, 1, 8'($urandom));
    checkOutput("frozen pos", int'(obstaclePos[0 +: PW]), 159);
    checkOutput("frozen valid", int'(obstacleValid), 1);
    applyStimulus(1, 1, 1, 8'($urandom));
    checkOutput("frozen start valid", int'(obstacleValid), 0);
    checkOutput("frozen start pos", int'(obstaclePos[0 +: PW]), 0);
    checkOutput("frozen start speed", int'(speedOut), 1);

    // Speed ramp over continuous ticks with random spawns.
    for (int t = 1; t <= 3000; t++) begin
      applyStimulus(1, 0, 0, 8'($urandom));
      if (t == 599)  checkOutput("speed before 600", int'(speedOut), 1);
      if (t == 600)  checkOutput("speed at 600", int'(speedOut), 2);
      if (t == 1200) checkOutput("speed at 1200", int'(speedOut), 3);
      if (t == 1800) checkOutput("speed at 1800", int'(speedOut), 4);
      if (t == 3000) checkOutput("speed at 3000", int'(speedOut), 4);
    end

    // Free-running random traffic with occasional freezes and restarts.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 499) == 0),
                    ($urandom_range(0, 7) == 0),
                    8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
